// File: rtl/spi_glue_regs.sv
// spi_glue_regs
//   Clock-domain back end for an SPI slave byte shifter. Resynchronises CS and
//   the shifter's octet flag into clk_i, decodes command/address/data frames,
//   holds an 8-bit register bank and supplies the next byte for MISO.
//
//   Frame: byte 0 = command (bit7 = 1 read, 0 write; bits[6:0] = start address),
//          following bytes = data (write) or don't-care (read); address
//          auto-increments with 7-bit wrap.
//
// Ports
//   clk_i        system clock (>= 16x SCK)
//   rst_n_i      asynchronous active-low reset
//   spi_cs_i     raw chip select, active low, asynchronous
//   new_octet_i  shifter flag, high while its bit counter == 7, asynchronous
//   rx_byte_i    shifter receive register
//   tx_byte_o    byte for the shifter to transmit next
//   regs_o       flat register bank, reg n at [8n+7:8n], reg 0 = ID_VALUE
//   wr_stb_o     one-clk pulse per accepted register write
//   wr_addr_o    address of the last write
//   wr_data_o    data of the last write
//   busy_o       high while a frame is active
module spi_glue_regs #(
   parameter int          NREGS    = 16,     // 2..128
   parameter logic [7:0]  ID_VALUE = 8'hA5
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 spi_cs_i,
   input  logic                 new_octet_i,
   input  logic [7:0]           rx_byte_i,
   output logic [7:0]           tx_byte_o,
   output logic [8*NREGS-1:0]   regs_o,
   output logic                 wr_stb_o,
   output logic [6:0]           wr_addr_o,
   output logic [7:0]           wr_data_o,
   output logic                 busy_o
);

   typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

   localparam logic [7:0] NREGS_W = 8'(NREGS);

   state_t                  state;
   logic [1:0]              cs_sync;
   logic [2:0]              oct_sync;
   logic [1:0]              warm;
   logic                    armed;
   logic [6:0]              ptr;
   logic [NREGS-1:1][7:0]   bank;

   logic cs_high, byte_done, byte_ok, wr_en;

   assign cs_high   = cs_sync[1];
   // Shifter flag drops on the 8th SCK edge, when rx_byte_i becomes complete.
   assign byte_done = oct_sync[2] & ~oct_sync[1];
   assign byte_ok   = byte_done & ~cs_high;
   assign wr_en     = byte_ok && (state == WR) && (ptr != 7'd0) &&
                      ({1'b0, ptr} < NREGS_W);

   function automatic logic [7:0] rd_data(input logic [6:0] a);
      logic [7:0] d;
      d = 8'h00;
      if (a == 7'd0) d = ID_VALUE;
      for (int i = 1; i < NREGS; i++)
         if (a == 7'(i)) d = bank[i];
      return d;
   endfunction

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cs_sync  <= 2'b11;
         oct_sync <= 3'b000;
         warm     <= 2'b00;
      end else begin
         cs_sync  <= {cs_sync[0], spi_cs_i};
         oct_sync <= {oct_sync[1:0], new_octet_i};
         warm     <= {warm[0], 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bank <= '0;
      end else begin
         for (int i = 1; i < NREGS; i++)
            if (wr_en && ptr == 7'(i)) bank[i] <= rx_byte_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= IDLE;
         tx_byte_o <= ID_VALUE;
         ptr       <= 7'd0;
         busy_o    <= 1'b0;
         wr_stb_o  <= 1'b0;
         wr_addr_o <= 7'd0;
         wr_data_o <= 8'h00;
         armed     <= 1'b0;
      end else begin
         wr_stb_o <= 1'b0;
         if (wr_en) begin
            wr_stb_o  <= 1'b1;
            wr_addr_o <= ptr;
            wr_data_o <= rx_byte_i;
         end
         if (cs_high) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            tx_byte_o <= ID_VALUE;
            // A reset inside a frame must not pick up that frame halfway:
            // only a CS-high seen with real (post-reset) samples re-arms.
            if (warm[1]) armed <= 1'b1;
         end else begin
            unique case (state)
               IDLE: if (armed) begin
                  state  <= CMD;
                  busy_o <= 1'b1;
               end
               CMD: if (byte_ok) begin
                  ptr <= rx_byte_i[6:0];
                  if (rx_byte_i[7]) begin
                     state     <= RD;
                     tx_byte_o <= rd_data(rx_byte_i[6:0]);
                  end else begin
                     state     <= WR;
                     tx_byte_o <= 8'h00;
                  end
               end
               WR: if (byte_ok) ptr <= ptr + 7'd1;
               RD: if (byte_ok) begin
                  ptr       <= ptr + 7'd1;
                  tx_byte_o <= rd_data(ptr + 7'd1);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_out
      if (g == 0) begin : g_id
         assign regs_o[7:0] = ID_VALUE;
      end else begin : g_reg
         assign regs_o[8*g +: 8] = bank[g];
      end
   end

endmodule

// File: tb/tb_spi_glue_regs.sv
// tb_spi_glue_regs
//   Drives an SPI mode-0 byte shifter model (bit counter, receive shift
//   register, tx load at byte start) into spi_glue_regs and checks MISO
//   bytes, write strobes and the register bank against a register-array
//   model of the frame protocol. Directed frames first, then random frames
//   with the clk/SCK phase swept over 16 steps.
`timescale 1ns/1ps
module tb_spi_glue_regs;
   localparam int         NREGS = 16;
   localparam logic [7:0] ID    = 8'hA5;
   localparam realtime    HALF  = 80.0;   // SCK = clk / 16

   logic                clk = 1'b0, rst_n = 1'b0, cs = 1'b1, oct = 1'b0;
   logic [7:0]          rx = 8'h00;
   logic [7:0]          tx_byte;
   logic [8*NREGS-1:0]  regs;
   logic                wr_stb, busy;
   logic [6:0]          wr_addr;
   logic [7:0]          wr_data;

   spi_glue_regs #(.NREGS(NREGS), .ID_VALUE(ID)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .spi_cs_i(cs), .new_octet_i(oct),
      .rx_byte_i(rx), .tx_byte_o(tx_byte), .regs_o(regs),
      .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .busy_o(busy));

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   int          bitcnt = 0;
   logic [7:0]  mem [NREGS];
   logic [14:0] last_wr;
   logic [14:0] exp_wr [$];
   logic [14:0] got_wr [$];
   logic [7:0]  fb [8];

   always @(negedge clk) if (wr_stb) got_wr.push_back({wr_addr, wr_data});

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mrd(input logic [6:0] a);
      if (a == 7'd0) return ID;
      if (int'(a) < NREGS) return mem[a];
      return 8'h00;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) mem[i] = 8'h00;
      last_wr = '0;
   endtask

   // Shifter: tx byte is latched at byte start, bits shift in on SCK rise.
   task automatic spi_byte(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
      miso = tx_byte;
      for (int b = 0; b < nbits; b++) begin
         #(HALF);
         rx     = {rx[6:0], mosi[7-b]};
         bitcnt = (bitcnt + 1) % 8;
         oct    = (bitcnt == 7);
         #(HALF);
      end
   endtask

   task automatic cs_up();
      cs = 1'b1; bitcnt = 0; oct = 1'b0;
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      for (int i = 0; i < NREGS; i++)
         chk({tag, "_reg"}, regs[8*i +: 8], (i == 0) ? ID : mem[i]);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_tx"}, tx_byte, ID);
      chk({tag, "_stb"}, wr_stb, 1'b0);
      chk({tag, "_last"}, {wr_addr, wr_data}, last_wr);
   endtask

   task automatic chk_wr(input string tag);
      chk({tag, "_wrcnt"}, got_wr.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
         chk({tag, "_wr"}, got_wr[i], exp_wr[i]);
   endtask

   task automatic frame_start(input int ph);
      @(posedge clk);
      #(ph * 0.625 + 0.3);
      got_wr.delete(); exp_wr.delete();
      cs = 1'b0;
      #(HALF);
   endtask

   task automatic run_frame(input int n, input int ph);
      logic [7:0] miso;
      logic [6:0] p;
      logic       rd;
      frame_start(ph);
      rd = fb[0][7];
      p  = fb[0][6:0];
      for (int k = 0; k < n; k++) begin
         spi_byte(fb[k], 8, miso);
         if (k == 0) begin
            chk("miso_cmd", miso, ID);
         end else if (rd) begin
            chk("miso_rd", miso, mrd(p));
            p = p + 7'd1;
         end else begin
            chk("miso_wr", miso, 8'h00);
            if (p != 7'd0 && int'(p) < NREGS) begin
               mem[p]  = fb[k];
               last_wr = {p, fb[k]};
               exp_wr.push_back({p, fb[k]});
            end
            p = p + 7'd1;
         end
         if (k == 0) chk("busy_mid", busy, 1'b1);
      end
      cs_up();
      chk_wr("frm");
      chk_idle("frm");
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx"}, tx_byte, ID);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_stb"}, wr_stb, 1'b0);
      chk({tag, "_addr"}, wr_addr, 7'd0);
      chk({tag, "_data"}, wr_data, 8'h00);
      for (int i = 0; i < NREGS; i++)
         chk({tag, "_reg"}, regs[8*i +: 8], (i == 0) ? ID : 8'h00);
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] m;
      model_reset();
      repeat (3) @(posedge clk);
      #1 chk_reset("rst");
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // write frame, then read it back
      fb = '{8'h02, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(3, 0);
      fb = '{8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(3, 1);
      // boundary addresses
      fb = '{8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(2, 2);
      fb = '{8'h7F, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(3, 3);
      fb = '{8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(2, 4);
      fb = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(3, 5);

      // abort mid data byte
      frame_start(6);
      spi_byte(8'h04, 8, m);
      spi_byte(8'hEE, 4, m);
      cs_up();
      chk("abort_nostb", got_wr.size(), 0);
      chk_idle("abort");

      // reset inside a write frame
      frame_start(7);
      spi_byte(8'h05, 8, m);
      spi_byte(8'h77, 8, m);
      @(negedge clk) rst_n = 1'b0;
      model_reset();
      #1 chk_reset("rstmid");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      got_wr.delete();
      spi_byte(8'h06, 8, m);
      #1 chk("rstmid_busy", busy, 1'b0);
      spi_byte(8'h99, 8, m);
      cs_up();
      chk("rstmid_nostb", got_wr.size(), 0);
      chk_idle("rstmid");
      fb = '{8'h01, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(2, 8);
      fb = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame(3, 9);

      // random frames, phase swept
      for (int f = 0; f < 48; f++) begin
         logic [6:0] a;
         int n;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(120, 127))
                                         : 7'($urandom_range(0, 19));
         fb[0] = {1'($urandom_range(0, 1)), a};
         for (int k = 1; k < 8; k++) fb[k] = 8'($urandom);
         n = $urandom_range(2, 6);
         run_frame(n, f % 16);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
